// File: rtl/demux_seq_driver_pkg.sv
// Shared types and sizes for the demux sequencer.
// Optional feature macro: DEMUX_SEQ_MASK_EN (channel skip mask).
package demux_seq_pkg;

  localparam int N_CH  = 8;
  localparam int CH_W  = 3;
  localparam int GAP_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/demux_seq_driver_if.sv
// Word handshake plus demux drive bundle for the demux sequencer.
// Optional feature macro: DEMUX_SEQ_MASK_EN adds in_mask to the bundle.
interface demux_seq_driver_if;
  import demux_seq_pkg::*;

  logic [N_CH-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
`ifdef DEMUX_SEQ_MASK_EN
  logic [N_CH-1:0] in_mask;
`endif
  logic            dmx_i;
  logic [CH_W-1:0] dmx_s;
  logic            dmx_en;
  logic            busy;
  logic            done;

`ifdef DEMUX_SEQ_MASK_EN
  modport master (
    output in_data, in_valid, in_mask,
    input  in_ready, dmx_i, dmx_s, dmx_en, busy, done
  );
  modport slave (
    input  in_data, in_valid, in_mask,
    output in_ready, dmx_i, dmx_s, dmx_en, busy, done
  );
`else
  modport master (
    output in_data, in_valid,
    input  in_ready, dmx_i, dmx_s, dmx_en, busy, done
  );
  modport slave (
    input  in_data, in_valid,
    output in_ready, dmx_i, dmx_s, dmx_en, busy, done
  );
`endif

endinterface

// File: rtl/demux_seq_next_ch.sv
// Priority finder: next unmasked channel after ch (or from 0 when first=1),
// and whether that channel is the final unmasked one.
// Used only when DEMUX_SEQ_MASK_EN is defined.
module demux_seq_next_ch
  import demux_seq_pkg::*;
(
  input  logic [CH_W-1:0] ch,
  input  logic            first,
  input  logic [N_CH-1:0] mask,
  output logic [CH_W-1:0] nxt,
  output logic            found,
  output logic            last
);

  // First candidate wins; any later candidate means nxt is not the last.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    last  = 1'b1;
    for (int c = 0; c < N_CH; c++) begin
      if (!mask[c] && (first || (c > int'(ch)))) begin
        if (!found) begin
          found = 1'b1;
          nxt   = CH_W'(c);
        end else begin
          last = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/demux_seq_driver.sv
// Sequencer feeding a 1-to-8 enabled demux: takes a word over valid/ready,
// strobes one bit per cycle onto channels in ascending order, pulses done
// on the final strobe, then idles GAP_CYCLES before accepting again.
// Optional feature macro: DEMUX_SEQ_MASK_EN (skip masked channels).
module demux_seq_driver
  import demux_seq_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic               clk,
  input  logic               rst,
  demux_seq_driver_if.slave  bus
);

  localparam logic [GAP_W-1:0] GAP_LOAD =
    GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  state_e          state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [N_CH-1:0] word_q, word_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic            last_q, last_d;
  logic            dmx_i_q, dmx_i_d;
  logic [CH_W-1:0] dmx_s_q, dmx_s_d;
  logic            dmx_en_q, dmx_en_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [CH_W-1:0] nxt_ch;
  logic            nxt_found;
  logic            nxt_last;
  logic [N_CH-1:0] src_word;

  // At the handshake the strobe comes straight from the input word.
  assign src_word = (state_q == IDLE) ? bus.in_data : word_q;

`ifdef DEMUX_SEQ_MASK_EN
  logic [N_CH-1:0] mask_q, mask_d;
  logic [N_CH-1:0] src_mask;

  assign src_mask = (state_q == IDLE) ? bus.in_mask : mask_q;

  demux_seq_next_ch u_next_ch (
    .ch    (ch_q),
    .first (state_q == IDLE),
    .mask  (src_mask),
    .nxt   (nxt_ch),
    .found (nxt_found),
    .last  (nxt_last)
  );
`else
  // Unmasked walk: channel 0 first, then +1, final channel is N_CH-1.
  always_comb begin
    nxt_found = 1'b1;
    if (state_q == IDLE) begin
      nxt_ch   = '0;
      nxt_last = 1'b0;
    end else begin
      nxt_ch   = ch_q + 1'b1;
      nxt_last = (ch_q == CH_W'(N_CH - 2));
    end
  end
`endif

  // Next-state and next-output decode; outputs are computed one cycle ahead.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    word_d   = word_q;
    gap_d    = gap_q;
    last_d   = last_q;
    busy_d   = busy_q;
    dmx_i_d  = 1'b0;
    dmx_s_d  = '0;
    dmx_en_d = 1'b0;
    done_d   = 1'b0;
`ifdef DEMUX_SEQ_MASK_EN
    mask_d   = mask_q;
`endif
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.in_valid) begin
          word_d  = bus.in_data;
`ifdef DEMUX_SEQ_MASK_EN
          mask_d  = bus.in_mask;
`endif
          state_d = SCAN;
          busy_d  = 1'b1;
          if (nxt_found) begin
            ch_d     = nxt_ch;
            dmx_en_d = 1'b1;
            dmx_s_d  = nxt_ch;
            dmx_i_d  = src_word[nxt_ch];
            done_d   = nxt_last;
            last_d   = nxt_last;
          end else begin
            // Everything masked: one empty SCAN cycle carrying done.
            done_d = 1'b1;
            last_d = 1'b1;
          end
        end
      end
      SCAN: begin
        busy_d = 1'b1;
        if (last_q) begin
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            gap_d   = GAP_LOAD;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          ch_d     = nxt_ch;
          dmx_en_d = 1'b1;
          dmx_s_d  = nxt_ch;
          dmx_i_d  = src_word[nxt_ch];
          done_d   = nxt_last;
          last_d   = nxt_last;
        end
      end
      GAP: begin
        busy_d = 1'b1;
        if (gap_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any scan without done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      word_q   <= '0;
      gap_q    <= '0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      dmx_i_q  <= 1'b0;
      dmx_s_q  <= '0;
      dmx_en_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef DEMUX_SEQ_MASK_EN
      mask_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      word_q   <= word_d;
      gap_q    <= gap_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      dmx_i_q  <= dmx_i_d;
      dmx_s_q  <= dmx_s_d;
      dmx_en_q <= dmx_en_d;
      done_q   <= done_d;
`ifdef DEMUX_SEQ_MASK_EN
      mask_q   <= mask_d;
`endif
    end
  end

  assign bus.in_ready = (state_q == IDLE) && !rst;
  assign bus.dmx_i    = dmx_i_q;
  assign bus.dmx_s    = dmx_s_q;
  assign bus.dmx_en   = dmx_en_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: doc/demux_seq_driver.md
# demux_seq_driver

Sequencer that sits directly upstream of the 1-to-8 enabled demultiplexer. It accepts an 8-bit word over a valid/ready handshake, then strobes each bit onto the demux data input one channel per cycle, driving data, select and enable. Consumers downstream see one bit routed to each channel `F[n]` in ascending order, followed by a one-cycle completion pulse.

## Interface
Parameters:
- `GAP_CYCLES`, default 0: idle cycles inserted after each word before the next is accepted. Legal range 0..15.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_data`  in  8  word to distribute; bit n goes to channel n.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a word.
- `in_mask`  in  8  channel skip mask, 1 means skip. Present only with `DEMUX_SEQ_MASK_EN`.
- `dmx_i`  out  1  drives demux `i`.
- `dmx_s`  out  3  drives demux `S`.
- `dmx_en`  out  1  drives demux `En`.
- `busy`  out  1  high in SCAN or GAP.
- `done`  out  1  one-cycle pulse on the final strobe of a word.

## Operation
- FSM states and transitions:
  - IDLE: `in_ready`=1. On `in_valid && in_ready`, capture `in_data` (and `in_mask`) and load the channel counter, then go to SCAN.
  - SCAN:
    - Each cycle: `dmx_en`=1, `dmx_s`=ch, `dmx_i`=word[ch].
    - Advance ch by +1 (or to the next unmasked channel).
    - On the last channel, pulse `done`, then go to GAP if `GAP_CYCLES`>0, else IDLE.
  - GAP: count down `GAP_CYCLES`, then go to IDLE. `in_ready`=0.
- When `dmx_en`=0, `dmx_i`=0 and `dmx_s`=0. The demux therefore never sees X-driving select or data from this block.
- `in_data` is sampled only at the handshake. Later changes have no effect on a scan in progress.
- `in_valid` without `in_ready` is held off with no loss. The source keeps the word stable.
- Channel counter is 3 bits. Termination is on ch==7 (or the last unmasked channel), never on wrap.
- Reset:
  - While `rst`=1, all outputs are forced 0: `in_ready`, `dmx_*`, `busy`, `done`.
  - Reset mid-SCAN or mid-GAP aborts immediately, with no `done`. State goes to IDLE.

## Timing
- Handshake at edge k:
  - Strobes for ch 0..7 are visible in cycles k+1..k+8.
  - `done` is high in cycle k+8, coincident with the ch 7 strobe.
- `in_ready` returns in cycle k+9+`GAP_CYCLES`.
- Throughput with `GAP_CYCLES`=0: one word per 9 cycles.
- All outputs are registered except `in_ready`, which is decoded from state.
- First handshake is possible in the first cycle after `rst` deasserts.

## Configuration
- `DEMUX_SEQ_MASK_EN` defined:
  - `in_mask` port exists and is captured at the handshake.
  - Masked channels receive no strobe, and SCAN skips them with no idle cycle. A scan lasts popcount(~mask) cycles.
  - All-ones mask: no strobes. SCAN lasts one cycle with `dmx_en`=0 and `done`=1 (cycle k+1).
- Not defined:
  - No `in_mask` port.
  - All 8 channels are always strobed, so every scan is exactly 8 cycles.

## Structure
- Shared package `demux_seq_pkg`:
  - state enum {IDLE, SCAN, GAP}.
  - `N_CH`=8, `CH_W`=3, `GAP_W`=4.
- Sub-module `demux_seq_next_ch`: combinational priority finder. Given the current ch and the mask, it returns the next unmasked channel and a last flag.
  - Instantiated only under `DEMUX_SEQ_MASK_EN`.
  - Otherwise the counter is ch+1 and last is ch==7.

## Test plan
- Word 8'hA5, `GAP_CYCLES`=0:
  - `dmx_s` = 0..7 in cycles k+1..k+8.
  - `dmx_i` = 1,0,1,0,0,1,0,1.
  - `done` only in cycle k+8; `in_ready`=1 in cycle k+9.
- Back-to-back words 8'hFF then 8'h00 with `in_valid` held high:
  - Second handshake at edge k+9.
  - No strobe is dropped or duplicated.
- `GAP_CYCLES`=3:
  - `in_ready`=0 in cycles k+9..k+11; `busy`=1 through GAP.
  - `in_ready`=1 in cycle k+12.
- `rst` asserted in cycle k+4 of a scan:
  - Next cycle: all outputs 0, no `done`.
  - A new word 8'h01 then scans correctly from ch 0.
- With `DEMUX_SEQ_MASK_EN`:
  - Mask 8'b1010_1010, word 8'hFF: strobes only on ch 0,2,4,6 in 4 cycles, `done` on ch 6.
  - Mask 8'hFF: single cycle with `dmx_en`=0 and `done`=1.
- `in_valid` toggled with an 8'h3C → 8'hC3 change during SCAN:
  - Scan outputs follow the captured 8'h3C only.
  - `in_ready` stays 0.
